// File: rtl/mmio_ctrl_if.sv
// -----------------------------------------------------------------------------
// mmio_ctrl_if
// CPU data-port bundle between the CPU and the memory-mapped I/O controller.
//
//   addr        CPU data address                  (CPU -> controller)
//   wdata       CPU store data                    (CPU -> controller)
//   we          store strobe, held while stall=1  (CPU -> controller)
//   re          load strobe, held while stall=1   (CPU -> controller)
//   rdata       registered load result            (controller -> CPU)
//   rdata_valid one-cycle pulse, rdata valid      (controller -> CPU)
//   stall       CPU must hold request and pipeline (controller -> CPU)
//
// Modports: master = CPU side, slave = controller side.
// -----------------------------------------------------------------------------
interface mmio_ctrl_if;
   logic [15:0] addr;
   logic [15:0] wdata;
   logic        we;
   logic        re;
   logic [15:0] rdata;
   logic        rdata_valid;
   logic        stall;

   modport master (
      output addr, wdata, we, re,
      input  rdata, rdata_valid, stall
   );

   modport slave (
      input  addr, wdata, we, re,
      output rdata, rdata_valid, stall
   );
endinterface

// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
// Memory-mapped I/O controller between the CPU data port and the SPART serial
// interface plus board LEDs/switches. Out of reset it writes BAUD_DIV into the
// SPART divisor registers, then decodes CPU loads/stores in 0xC000-0xC007:
//   0xC000 LEDR (W)            0xC001 SW (R)
//   0xC004 SPART data (W/R)    0xC005 SPART status (R)
//   0xC006 divisor low (W)     0xC007 divisor high (W)
// Unmapped stores are ignored; unmapped loads return 0x0000.
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   cpu          CPU data port (mmio_ctrl_if.slave)
//   iocs_n       SPART chip select, active-low
//   iorw_n       SPART direction, 1 = read, 0 = write
//   ioaddr       SPART register: 0 data, 1 status, 2 div low, 3 div high
//   io_wdata     byte to SPART
//   io_rdata     byte from SPART (valid while iocs_n=0, iorw_n=1)
//   tx_q_full    SPART TX queue full
//   rx_q_empty   SPART RX queue empty
//   sw           board switches
//   ledr         board LEDs
// -----------------------------------------------------------------------------
module mmio_ctrl #(
   parameter logic [15:0] BAUD_DIV = 16'd324
) (
   input  logic       clk,
   input  logic       rst_n,
   mmio_ctrl_if.slave cpu,
   output logic       iocs_n,
   output logic       iorw_n,
   output logic [1:0] ioaddr,
   output logic [7:0] io_wdata,
   input  logic [7:0] io_rdata,
   input  logic       tx_q_full,
   input  logic       rx_q_empty,
   input  logic [9:0] sw,
   output logic [9:0] ledr
);

   localparam logic [15:0] ADDR_LEDR   = 16'hC000;
   localparam logic [15:0] ADDR_SW     = 16'hC001;
   localparam logic [15:0] ADDR_DATA   = 16'hC004;
   localparam logic [15:0] ADDR_STATUS = 16'hC005;
   localparam logic [15:0] ADDR_DIV_LO = 16'hC006;
   localparam logic [15:0] ADDR_DIV_HI = 16'hC007;

   typedef enum logic [2:0] {
      S_INIT_LO,
      S_INIT_HI,
      S_IDLE,
      S_WAIT_TX,
      S_BUS,
      S_RD
   } state_t;

   // Where the RD cycle takes its result from.
   typedef enum logic [1:0] {
      SRC_ZERO,
      SRC_SW,
      SRC_SPART
   } rd_src_t;

   state_t  state;
   rd_src_t rd_src;

   // Store decode: SPART-bound stores and their register index.
   logic       wr_spart;
   logic [1:0] wr_ioaddr;
   // Load decode: result source, whether the SPART is strobed, and where.
   rd_src_t    rd_src_next;
   logic       rd_strobe;
   logic [1:0] rd_ioaddr;

   // Store data above the LED width is never consumed.
   logic unused_wdata_hi;
   assign unused_wdata_hi = ^cpu.wdata[15:10];

   always_comb begin
      // NOTE: every output of this block gets a default before the case, so no
      // path leaves one unassigned and no latch is inferred.
      wr_spart    = 1'b0;
      wr_ioaddr   = 2'd0;
      rd_src_next = SRC_ZERO;
      rd_strobe   = 1'b0;
      rd_ioaddr   = 2'd0;
      case (cpu.addr)
         ADDR_SW: rd_src_next = SRC_SW;
         ADDR_DATA: begin
            wr_spart = 1'b1;
            // An empty RX queue is never popped; the load simply returns zero.
            if (!rx_q_empty) begin
               rd_src_next = SRC_SPART;
               rd_strobe   = 1'b1;
            end
         end
         ADDR_STATUS: begin
            rd_src_next = SRC_SPART;
            rd_strobe   = 1'b1;
            rd_ioaddr   = 2'd1;
         end
         ADDR_DIV_LO: begin
            wr_spart  = 1'b1;
            wr_ioaddr = 2'd2;
         end
         ADDR_DIV_HI: begin
            wr_spart  = 1'b1;
            wr_ioaddr = 2'd3;
         end
         default: ;
      endcase
   end

   // All bus and CPU-facing outputs are registered here; each state sets up
   // what the following cycle presents.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_INIT_LO;
         rd_src          <= SRC_ZERO;
         iocs_n          <= 1'b1;
         iorw_n          <= 1'b1;
         ioaddr          <= 2'd0;
         io_wdata        <= 8'd0;
         ledr            <= 10'd0;
         cpu.rdata       <= 16'd0;
         cpu.rdata_valid <= 1'b0;
         cpu.stall       <= 1'b1;
      end else begin
         cpu.rdata_valid <= 1'b0;
         case (state)
            S_INIT_LO: begin
               iocs_n   <= 1'b0;
               iorw_n   <= 1'b0;
               ioaddr   <= 2'd2;
               io_wdata <= BAUD_DIV[7:0];
               state    <= S_INIT_HI;
            end
            S_INIT_HI: begin
               iocs_n   <= 1'b0;
               iorw_n   <= 1'b0;
               ioaddr   <= 2'd3;
               io_wdata <= BAUD_DIV[15:8];
               state    <= S_IDLE;
            end
            S_IDLE: begin
               iocs_n    <= 1'b1;
               iorw_n    <= 1'b1;
               cpu.stall <= 1'b0;
               // stall is still high in the first IDLE cycle after init, while
               // the divisor-high write is on the bus; requests wait for it.
               if (!cpu.stall) begin
                  if (cpu.we) begin
                     if (cpu.addr == ADDR_LEDR) begin
                        ledr <= cpu.wdata[9:0];
                     end else if (wr_spart) begin
                        ioaddr   <= wr_ioaddr;
                        io_wdata <= cpu.wdata[7:0];
                        if (cpu.addr == ADDR_DATA && tx_q_full) begin
                           cpu.stall <= 1'b1;
                           state     <= S_WAIT_TX;
                        end else begin
                           iocs_n <= 1'b0;
                           iorw_n <= 1'b0;
                           state  <= S_BUS;
                        end
                     end
                  end else if (cpu.re) begin
                     cpu.stall <= 1'b1;
                     rd_src    <= rd_src_next;
                     iocs_n    <= ~rd_strobe;
                     if (rd_strobe) ioaddr <= rd_ioaddr;
                     state     <= S_RD;
                  end
               end
            end
            S_WAIT_TX: begin
               if (!tx_q_full) begin
                  iocs_n <= 1'b0;
                  iorw_n <= 1'b0;
                  state  <= S_BUS;
               end
            end
            S_BUS: begin
               iocs_n    <= 1'b1;
               iorw_n    <= 1'b1;
               cpu.stall <= 1'b0;
               state     <= S_IDLE;
            end
            S_RD: begin
               case (rd_src)
                  SRC_SW:    cpu.rdata <= {6'd0, sw};
                  SRC_SPART: cpu.rdata <= {8'd0, io_rdata};
                  default:   cpu.rdata <= 16'd0;
               endcase
               cpu.rdata_valid <= 1'b1;
               iocs_n          <= 1'b1;
               cpu.stall       <= 1'b0;
               state           <= S_IDLE;
            end
            default: state <= S_INIT_LO;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mmio_ctrl
// Self-checking bench for mmio_ctrl. Directed steps plus randomized loads and
// stores; expected values come from a transaction-level model of the address
// map (expected LED value, last load result, expected bus writes/reads).
// -----------------------------------------------------------------------------
module tb_mmio_ctrl;

   localparam logic [15:0] BAUD = 16'd324;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       iocs_n;
   logic       iorw_n;
   logic [1:0] ioaddr;
   logic [7:0] io_wdata;
   logic [7:0] io_rdata;
   logic       tx_q_full;
   logic       rx_q_empty;
   logic [9:0] sw;
   logic [9:0] ledr;

   // SPART model state: next RX byte and status byte.
   logic [7:0] rx_byte;
   logic [7:0] stat_byte;

   int n_checks  = 0;
   int n_errors  = 0;
   int bus_cnt   = 0;
   int valid_cnt = 0;

   // Reference model state.
   logic [9:0]  model_ledr;
   logic [15:0] model_rdata;

   always #5 clk = ~clk;

   mmio_ctrl_if cpu_if ();

   mmio_ctrl #(.BAUD_DIV(BAUD)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu        (cpu_if),
      .iocs_n     (iocs_n),
      .iorw_n     (iorw_n),
      .ioaddr     (ioaddr),
      .io_wdata   (io_wdata),
      .io_rdata   (io_rdata),
      .tx_q_full  (tx_q_full),
      .rx_q_empty (rx_q_empty),
      .sw         (sw),
      .ledr       (ledr)
   );

   // SPART read data only exists during a read strobe.
   assign io_rdata = (!iocs_n && iorw_n) ?
                     ((ioaddr == 2'd0) ? rx_byte : (ioaddr == 2'd1) ? stat_byte : 8'hEE) :
                     8'h00;

   // Count strobed SPART cycles and rdata_valid pulses.
   always @(negedge clk) begin
      if (rst_n && !iocs_n) bus_cnt++;
      if (rst_n && cpu_if.rdata_valid) valid_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, sample 1 ns later; the CPU drops its request once the
   // controller no longer stalls it.
   task automatic tick();
      @(posedge clk);
      #1;
      if (!cpu_if.stall) begin
         cpu_if.we = 1'b0;
         cpu_if.re = 1'b0;
      end
   endtask

   // Expected load result from the address map.
   function automatic logic [15:0] model_load(input logic [15:0] a, input logic [9:0] s,
                                              input logic empty, input logic [7:0] rxb,
                                              input logic [7:0] st);
      case (a)
         16'hC001: return {6'd0, s};
         16'hC004: return empty ? 16'h0000 : {8'h00, rxb};
         16'hC005: return {8'h00, st};
         default:  return 16'h0000;
      endcase
   endfunction

   task automatic check_reset_values();
      check("rst_iocs_n", 32'(iocs_n), 1);
      check("rst_iorw_n", 32'(iorw_n), 1);
      check("rst_ioaddr", 32'(ioaddr), 0);
      check("rst_io_wdata", 32'(io_wdata), 0);
      check("rst_ledr", 32'(ledr), 0);
      check("rst_rdata", 32'(cpu_if.rdata), 0);
      check("rst_rdata_valid", 32'(cpu_if.rdata_valid), 0);
      check("rst_stall", 32'(cpu_if.stall), 1);
   endtask

   // Called in the cycle rst_n has just risen.
   task automatic run_init();
      int b0;
      b0 = bus_cnt;
      tick();
      check("init_lo_cs", 32'(iocs_n), 0);
      check("init_lo_rw", 32'(iorw_n), 0);
      check("init_lo_addr", 32'(ioaddr), 2);
      check("init_lo_data", 32'(io_wdata), 32'(BAUD % 16'd256));
      check("init_lo_stall", 32'(cpu_if.stall), 1);
      tick();
      check("init_hi_cs", 32'(iocs_n), 0);
      check("init_hi_rw", 32'(iorw_n), 0);
      check("init_hi_addr", 32'(ioaddr), 3);
      check("init_hi_data", 32'(io_wdata), 32'(BAUD / 16'd256));
      check("init_hi_stall", 32'(cpu_if.stall), 1);
      tick();
      check("init_done_cs", 32'(iocs_n), 1);
      check("init_done_stall", 32'(cpu_if.stall), 0);
      check("init_bus_count", 32'(bus_cnt - b0), 2);
   endtask

   // Store in the current cycle; tx_q_full stays high for nfull cycles.
   task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                           input int nfull, input bit also_re);
      int         b0;
      int         v0;
      bit         spart;
      bit         waits;
      logic [1:0] exp_io;
      b0     = bus_cnt;
      v0     = valid_cnt;
      spart  = (a == 16'hC004) || (a == 16'hC006) || (a == 16'hC007);
      waits  = (a == 16'hC004) && (nfull > 0);
      exp_io = (a == 16'hC004) ? 2'd0 : (a == 16'hC006) ? 2'd2 : 2'd3;
      if (a == 16'hC000) model_ledr = d[9:0];
      cpu_if.addr  = a;
      cpu_if.wdata = d;
      cpu_if.we    = 1'b1;
      cpu_if.re    = also_re;
      tx_q_full    = (nfull > 0);
      tick();
      check("st_ledr", 32'(ledr), 32'(model_ledr));
      if (waits) begin
         for (int k = 1; k < nfull; k++) begin
            check("wait_stall", 32'(cpu_if.stall), 1);
            check("wait_cs", 32'(iocs_n), 1);
            tick();
         end
         tx_q_full = 1'b0;
         check("wait_stall", 32'(cpu_if.stall), 1);
         check("wait_cs", 32'(iocs_n), 1);
         tick();
         check("wr_stall_in_bus", 32'(cpu_if.stall), 1);
      end
      if (spart) begin
         check("wr_cs", 32'(iocs_n), 0);
         check("wr_rw", 32'(iorw_n), 0);
         check("wr_ioaddr", 32'(ioaddr), 32'(exp_io));
         check("wr_data", 32'(io_wdata), 32'(d[7:0]));
         if (!waits) check("wr_no_stall", 32'(cpu_if.stall), 0);
         tick();
      end
      tx_q_full = 1'b0;
      check("st_done_stall", 32'(cpu_if.stall), 0);
      check("st_done_cs", 32'(iocs_n), 1);
      if (also_re) begin
         tick();
         tick();
      end
      check("st_bus_count", 32'(bus_cnt - b0), spart ? 1 : 0);
      check("st_no_valid", 32'(valid_cnt - v0), 0);
      check("st_rdata_hold", 32'(cpu_if.rdata), 32'(model_rdata));
   endtask

   task automatic do_load(input logic [15:0] a, input logic empty, input logic [7:0] rxb,
                          input logic [7:0] st, input logic [9:0] s);
      int          b0;
      bit          strobe;
      logic [1:0]  exp_io;
      logic [15:0] exp;
      strobe     = (a == 16'hC005) || ((a == 16'hC004) && !empty);
      exp_io     = (a == 16'hC005) ? 2'd1 : 2'd0;
      exp        = model_load(a, s, empty, rxb, st);
      b0         = bus_cnt;
      rx_q_empty = empty;
      rx_byte    = rxb;
      stat_byte  = st;
      sw         = s;
      cpu_if.addr = a;
      cpu_if.we   = 1'b0;
      cpu_if.re   = 1'b1;
      tick();
      check("ld_stall", 32'(cpu_if.stall), 1);
      check("ld_valid_early", 32'(cpu_if.rdata_valid), 0);
      check("ld_cs", 32'(iocs_n), strobe ? 0 : 1);
      if (strobe) begin
         check("ld_rw", 32'(iorw_n), 1);
         check("ld_ioaddr", 32'(ioaddr), 32'(exp_io));
      end
      tick();
      check("ld_valid", 32'(cpu_if.rdata_valid), 1);
      check("ld_rdata", 32'(cpu_if.rdata), 32'(exp));
      check("ld_stall_done", 32'(cpu_if.stall), 0);
      check("ld_cs_done", 32'(iocs_n), 1);
      model_rdata = exp;
      // Sources change afterwards; the result must hold.
      sw      = ~s;
      rx_byte = ~rxb;
      tick();
      check("ld_valid_pulse", 32'(cpu_if.rdata_valid), 0);
      check("ld_rdata_hold", 32'(cpu_if.rdata), 32'(model_rdata));
      check("ld_bus_count", 32'(bus_cnt - b0), strobe ? 1 : 0);
   endtask

   initial begin
      int          b0;
      int          pick;
      logic [15:0] a;

      cpu_if.addr  = 16'h0000;
      cpu_if.wdata = 16'h0000;
      cpu_if.we    = 1'b0;
      cpu_if.re    = 1'b0;
      tx_q_full    = 1'b0;
      rx_q_empty   = 1'b1;
      sw           = 10'd0;
      rx_byte      = 8'h00;
      stat_byte    = 8'h00;
      model_ledr   = 10'd0;
      model_rdata  = 16'h0000;

      // Power-on reset.
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check_reset_values();
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run_init();

      // LED store: no bus activity, no stall.
      do_store(16'hC000, 16'h03A5, 0, 1'b0);
      // TX push waiting on a full queue for five cycles.
      do_store(16'hC004, 16'h0041, 5, 1'b0);
      // RX pop with data, then with an empty queue.
      do_load(16'hC004, 1'b0, 8'h5A, 8'h00, 10'h000);
      do_load(16'hC004, 1'b1, 8'h77, 8'h00, 10'h000);
      // Switches, unmapped load, unmapped store.
      do_load(16'hC001, 1'b1, 8'h00, 8'h00, 10'h2F0);
      do_load(16'hC003, 1'b0, 8'h12, 8'h34, 10'h3FF);
      do_store(16'hC003, 16'hFFFF, 0, 1'b0);
      // Divisor writes, status read, write-only LED location read.
      do_store(16'hC006, 16'h1234, 0, 1'b0);
      do_store(16'hC007, 16'h00AB, 1, 1'b0);
      do_load(16'hC005, 1'b1, 8'h00, 8'hC3, 10'h155);
      do_load(16'hC000, 1'b0, 8'h99, 8'h66, 10'h2AA);
      // Store and load together: the load is dropped.
      do_store(16'hC000, 16'h0155, 0, 1'b1);
      do_store(16'hC004, 16'h00E7, 0, 1'b1);

      // Randomized transactions.
      for (int i = 0; i < 40; i++) begin
         pick = int'($urandom_range(0, 8));
         a    = (pick == 8) ? 16'($urandom) : 16'hC000 + 16'(pick);
         if ($urandom_range(0, 1) == 1)
            do_store(a, 16'($urandom),
                     (a == 16'hC004) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0));
         else
            do_load(a, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 10'($urandom));
      end

      // Make sure LED and rdata are non-zero before the mid-operation reset.
      do_store(16'hC000, 16'h0201, 0, 1'b0);
      do_load(16'hC001, 1'b1, 8'h00, 8'h00, 10'h081);

      // Reset while a TX byte waits for queue space.
      cpu_if.addr  = 16'hC004;
      cpu_if.wdata = 16'h0099;
      cpu_if.we    = 1'b1;
      tx_q_full    = 1'b1;
      tick();
      check("rw_wait_stall", 32'(cpu_if.stall), 1);
      tick();
      check("rw_wait_cs", 32'(iocs_n), 1);
      rst_n     = 1'b0;
      cpu_if.we = 1'b0;
      #1 check_reset_values();
      model_ledr  = 10'd0;
      model_rdata = 16'h0000;
      tx_q_full   = 1'b0;
      tick();
      rst_n = 1'b1;
      b0    = bus_cnt;
      run_init();
      repeat (6) tick();
      check("rw_no_tx_after_reset", 32'(bus_cnt - b0), 2);
      check("rw_ledr", 32'(ledr), 32'(model_ledr));
      check("rw_rdata", 32'(cpu_if.rdata), 32'(model_rdata));
      check("rw_stall", 32'(cpu_if.stall), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
